// File: rtl/soc_pkg.sv
// soc_pkg: shared FSM encoding, error data default and standard SoC region map
package soc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] FRAM_BASE = 32'h1000_0000;
  localparam logic [31:0] RAM_BASE  = 32'h2000_0000;
  localparam logic [31:0] PWR_BASE  = 32'h4000_0000;
  localparam logic [31:0] UART_BASE = 32'h4000_1000;
  localparam logic [31:0] SPI_BASE  = 32'h4000_5000;
  localparam logic [31:0] SHA_BASE  = 32'h4000_6000;
  localparam logic [31:0] MEM_MASK  = 32'hF000_0000;
  localparam logic [31:0] PER_MASK  = 32'hFFFF_F000;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_fabric_decode.sv
// mem_fabric_decode: combinational address decode, lowest matching slave index wins
module mem_fabric_decode import soc_pkg::*; #(
  parameter int NUM_SLV = 7,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = '0,
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = '0
) (
  input  logic [31:0]                addr,
  output logic                       hit,
  output logic [sel_w(NUM_SLV)-1:0] idx
);
  localparam int SW = sel_w(NUM_SLV);
  // scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = i[SW-1:0];
      end
    end
  end
endmodule

// File: rtl/mem_fabric.sv
// mem_fabric: single-master to NUM_SLV-slave fabric; optional BUSY timeout via MEM_FABRIC_TIMEOUT_EN
module mem_fabric import soc_pkg::*; #(
  parameter int NUM_SLV = 7,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = '0,
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = '0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m_valid,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic [3:0]              m_wstrb,
  output logic                    m_ready,
  output logic [31:0]             m_rdata,
  output logic [NUM_SLV-1:0]      s_valid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic [NUM_SLV-1:0]      s_ready,
  input  logic [32*NUM_SLV-1:0]   s_rdata,
  output logic                    err_pulse,
  output logic [31:0]             err_addr
);
  localparam int SW = sel_w(NUM_SLV);
  state_t state, state_n;
  logic [SW-1:0] sel, dec_idx;
  logic dec_hit, s_ack, tmo;
  mem_fabric_decode #(
    .NUM_SLV (NUM_SLV),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK)
  ) u_decode (
    .addr(m_addr),
    .hit (dec_hit),
    .idx (dec_idx)
  );
  assign s_valid = (state == BUSY) ? NUM_SLV'(1) << sel : '0;
  assign m_ready = state == RESP;
  assign s_ack   = |(s_ready & s_valid);
`ifdef MEM_FABRIC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // BUSY cycle counter, held at zero outside BUSY so it starts clean on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
  end
  assign tmo = (state == BUSY) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state: decode miss skips BUSY, slave completion beats timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = m_valid ? (dec_hit ? BUSY : RESP) : IDLE;
      BUSY:    state_n = (s_ack || tmo) ? RESP : BUSY;
      default: state_n = IDLE;
    endcase
  end
  // request latch, response data and error reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      m_rdata   <= '0;
      err_pulse <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (state == IDLE && m_valid) begin
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        sel     <= dec_hit ? dec_idx : '0;
        if (!dec_hit) begin
          m_rdata   <= ERR_RDATA;
          err_pulse <= 1'b1;
          err_addr  <= m_addr;
        end
      end
      if (state == BUSY && s_ack) begin
        m_rdata <= s_rdata[32*sel +: 32];
      end else if (tmo) begin
        m_rdata   <= ERR_RDATA;
        err_pulse <= 1'b1;
        err_addr  <= s_addr;
      end
    end
  end
endmodule
